// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage sequencing controller: a per-register scoreboard of in-flight loads drives
// stall/flush controls for RAW hazards, EX redirects and data-memory freezes.
module hazard_scoreboard_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_ID,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  input  logic [4:0]           rd_ID,
  input  logic                 reg_write_ID,
  input  logic                 is_load_ID,
  input  logic                 redirect_EX,
  input  logic                 mem_busy,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 flush_IF_ID,
  output logic                 flush_ID_EX,
  output logic [31:0]          pending_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZ    = 2'd1,
    ST_FREEZE = 2'd2,
    ST_REDIR  = 2'd3
  } state_t;

  logic [31:0]          pending_q, pending_d;
  logic [4:0]           outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  state_t               state_q, state_d;

  logic hit1, hit2, raw, full;
  logic freeze_c, redir_c, hold_c, issue_c, set_c, dec_c;

  // A write-back landing this cycle already satisfies the reader, so it does not count as a hit.
  assign hit1 = use_rs1_ID && (rs1_ID != 5'd0) && pending_q[rs1_ID] &&
                !(wb_valid && (wb_rd == rs1_ID));
  assign hit2 = use_rs2_ID && (rs2_ID != 5'd0) && pending_q[rs2_ID] &&
                !(wb_valid && (wb_rd == rs2_ID));
  assign raw  = valid_ID && (hit1 || hit2);
  assign full = valid_ID && is_load_ID && reg_write_ID &&
                (outstanding_q == 5'(MAX_OUTSTANDING)) && !wb_valid;

  assign freeze_c = mem_busy;
  assign redir_c  = !mem_busy && redirect_EX;
  assign hold_c   = !mem_busy && !redirect_EX && (raw || full);
  assign issue_c  = !mem_busy && !redirect_EX && !(raw || full) && valid_ID;
  assign set_c    = issue_c && is_load_ID && reg_write_ID && (rd_ID != 5'd0);
  assign dec_c    = wb_valid && (wb_rd != 5'd0) && (outstanding_q != 5'd0);

  // Controls are held low while reset is asserted regardless of the inputs.
  assign stall_IF    = !rst && (freeze_c || hold_c);
  assign stall_ID    = !rst && (freeze_c || hold_c);
  assign stall_EX    = !rst && freeze_c;
  assign flush_IF_ID = !rst && redir_c;
  assign flush_ID_EX = !rst && (redir_c || hold_c);

  assign pending_o      = pending_q;
  assign stall_cycles_o = stall_cnt_q;
  assign state_o        = state_q;

  always_comb begin
    pending_d = pending_q;
    if (wb_valid && (wb_rd != 5'd0)) pending_d[wb_rd] = 1'b0;
    // Set after clear: a newer load to the same register keeps it pending.
    if (set_c) pending_d[rd_ID] = 1'b1;
    pending_d[0] = 1'b0;

    outstanding_d = outstanding_q;
    if (set_c && !dec_c)      outstanding_d = outstanding_q + 5'd1;
    else if (!set_c && dec_c) outstanding_d = outstanding_q - 5'd1;

    stall_cnt_d = stall_cnt_q;
    if (stall_ID && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_d = ST_RUN;
    if (freeze_c)     state_d = ST_FREEZE;
    else if (redir_c) state_d = ST_REDIR;
    else if (hold_c)  state_d = ST_HAZ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= 32'd0;
      outstanding_q <= 5'd0;
      stall_cnt_q   <= {CNT_WIDTH{1'b0}};
      state_q       <= ST_RUN;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
      state_q       <= state_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl: scenario tasks push expected control
// vectors into a queue as stimulus is driven and pop/compare them at the falling edge.
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_ID, use_rs1_ID, use_rs2_ID, reg_write_ID, is_load_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID, wb_rd;
  logic        redirect_EX, mem_busy, wb_valid;
  logic        stall_IF, stall_ID, stall_EX, flush_IF_ID, flush_ID_EX;
  logic [31:0] pending_o;
  logic [3:0]  stall_cycles_o;
  logic [1:0]  state_o;

  logic [4:0]  exp_q[$];
  logic [3:0]  exp_stalls;
  int          checks = 0;
  int          errors = 0;

  // {stall_IF, stall_ID, stall_EX, flush_IF_ID, flush_ID_EX}
  wire [4:0] ctrl = {stall_IF, stall_ID, stall_EX, flush_IF_ID, flush_ID_EX};

  hazard_scoreboard_ctrl #(.MAX_OUTSTANDING(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_ID(rd_ID),
    .reg_write_ID(reg_write_ID), .is_load_ID(is_load_ID), .redirect_EX(redirect_EX),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .pending_o(pending_o),
    .stall_cycles_o(stall_cycles_o), .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clr_inputs();
    valid_ID = 0; rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
    rd_ID = 0; reg_write_ID = 0; is_load_ID = 0;
    redirect_EX = 0; mem_busy = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    valid_ID = v; rs1_ID = r1; use_rs1_ID = u1; rs2_ID = r2; use_rs2_ID = u2;
    rd_ID = rd; reg_write_ID = rw; is_load_ID = ld;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bump_stalls();
    if (exp_stalls != 4'hF) exp_stalls = exp_stalls + 4'd1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    clr_inputs();
    rst = 1;
    mem_busy = 1; redirect_EX = 1;
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, e); end
    tick();
    @(negedge clk);
    checks++;
    if (pending_o !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h exp=0", pending_o); end
    checks++;
    if (stall_cycles_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles_o); end
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    exp_stalls = 0;
    tick();
    rst = 0;
    clr_inputs();
  endtask

  task automatic test_raw_load();
    logic [4:0] e;
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL raw_issue got=%b exp=%b", ctrl, e); end
    tick();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5'b11001);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL raw_stall[%0d] got=%b exp=%b", i, ctrl, e); end
      if (e[3]) bump_stalls();
      if (i == 0) begin
        checks++;
        if (pending_o !== 32'h20) begin errors++; $display("FAIL raw_pending got=%h exp=00000020", pending_o); end
      end
      if (i == 1) begin
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL raw_state got=%0d exp=1", state_o); end
      end
      tick();
    end
    wb_valid = 1; wb_rd = 5'd5;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL raw_release got=%b exp=%b", ctrl, e); end
    tick();
    clr_inputs();
    @(negedge clk);
    checks++;
    if (pending_o !== 32'd0) begin errors++; $display("FAIL raw_cleared got=%h exp=0", pending_o); end
    checks++;
    if (stall_cycles_o !== exp_stalls) begin errors++; $display("FAIL raw_cnt got=%0d exp=%0d", stall_cycles_o, exp_stalls); end
    tick();
  endtask

  task automatic test_full();
    logic [4:0] e;
    logic [4:0] drain [4];
    drain = '{5'd2, 5'd3, 5'd4, 5'd7};
    for (int k = 1; k <= 4; k++) begin
      set_id(1, 5'd0, 0, 5'd0, 0, 5'(k), 1, 1);
      exp_q.push_back(5'b00000);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL full_fill[%0d] got=%b exp=%b", k, ctrl, e); end
      tick();
    end
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    exp_q.push_back(5'b11001);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL full_stall got=%b exp=%b", ctrl, e); end
    bump_stalls();
    checks++;
    if (pending_o !== 32'h1E) begin errors++; $display("FAIL full_pending got=%h exp=0000001e", pending_o); end
    tick();
    wb_valid = 1; wb_rd = 5'd1;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL full_wb_release got=%b exp=%b", ctrl, e); end
    tick();
    wb_valid = 0; wb_rd = 0;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1);
    exp_q.push_back(5'b11001);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL full_still4 got=%b exp=%b", ctrl, e); end
    bump_stalls();
    checks++;
    if (pending_o !== 32'h9C) begin errors++; $display("FAIL full_swap got=%h exp=0000009c", pending_o); end
    tick();
    clr_inputs();
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1; wb_rd = drain[k];
      exp_q.push_back(5'b00000);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL full_drain[%0d] got=%b exp=%b", k, ctrl, e); end
      tick();
    end
    clr_inputs();
    @(negedge clk);
    checks++;
    if (pending_o !== 32'd0) begin errors++; $display("FAIL full_drained got=%h exp=0", pending_o); end
    checks++;
    if (stall_cycles_o !== exp_stalls) begin errors++; $display("FAIL full_cnt got=%0d exp=%0d", stall_cycles_o, exp_stalls); end
    tick();
  endtask

  task automatic test_redirect();
    logic [4:0] e;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL redir_issue got=%b exp=%b", ctrl, e); end
    tick();
    set_id(1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 1);
    redirect_EX = 1;
    exp_q.push_back(5'b00011);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL redir_ctrl got=%b exp=%b", ctrl, e); end
    tick();
    clr_inputs();
    @(negedge clk);
    checks++;
    if (pending_o !== 32'h400) begin errors++; $display("FAIL redir_pending got=%h exp=00000400", pending_o); end
    checks++;
    if (state_o !== 2'd3) begin errors++; $display("FAIL redir_state got=%0d exp=3", state_o); end
    tick();
    wb_valid = 1; wb_rd = 5'd10;
    tick();
    clr_inputs();
  endtask

  task automatic test_mem_busy();
    logic [4:0] e;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5'b11100);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL freeze_ctrl[%0d] got=%b exp=%b", i, ctrl, e); end
      bump_stalls();
      checks++;
      if (pending_o !== 32'd0) begin errors++; $display("FAIL freeze_pending[%0d] got=%h exp=0", i, pending_o); end
      if (i == 2) begin
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL freeze_state got=%0d exp=2", state_o); end
      end
      tick();
    end
    mem_busy = 0;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL freeze_release got=%b exp=%b", ctrl, e); end
    tick();
    clr_inputs();
    @(negedge clk);
    checks++;
    if (pending_o !== 32'h200) begin errors++; $display("FAIL freeze_set got=%h exp=00000200", pending_o); end
    checks++;
    if (stall_cycles_o !== exp_stalls) begin errors++; $display("FAIL freeze_cnt got=%0d exp=%0d", stall_cycles_o, exp_stalls); end
    tick();
    wb_valid = 1; wb_rd = 5'd9;
    tick();
    clr_inputs();
  endtask

  task automatic test_x0();
    logic [4:0] e;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL x0_load got=%b exp=%b", ctrl, e); end
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0);
    wb_valid = 1; wb_rd = 5'd0;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL x0_use got=%b exp=%b", ctrl, e); end
    checks++;
    if (pending_o !== 32'd0) begin errors++; $display("FAIL x0_pending got=%h exp=0", pending_o); end
    tick();
    clr_inputs();
  endtask

  task automatic test_saturate_and_reset();
    logic [4:0] e;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL sat_issue got=%b exp=%b", ctrl, e); end
    tick();
    set_id(1, 5'd12, 1, 5'd12, 1, 5'd13, 1, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(5'b11001);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL sat_stall[%0d] got=%b exp=%b", i, ctrl, e); end
      bump_stalls();
      tick();
    end
    @(negedge clk);
    checks++;
    if (stall_cycles_o !== exp_stalls) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", stall_cycles_o, exp_stalls); end
    tick();
    rst = 1;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL midrst_ctrl got=%b exp=%b", ctrl, e); end
    tick();
    rst = 0;
    exp_stalls = 0;
    wb_valid = 1; wb_rd = 5'd12;
    exp_q.push_back(5'b00000);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ctrl !== e) begin errors++; $display("FAIL postrst_ctrl got=%b exp=%b", ctrl, e); end
    checks++;
    if (pending_o !== 32'd0) begin errors++; $display("FAIL postrst_pending got=%h exp=0", pending_o); end
    checks++;
    if (stall_cycles_o !== 4'd0) begin errors++; $display("FAIL postrst_cnt got=%0d exp=0", stall_cycles_o); end
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL postrst_state got=%0d exp=0", state_o); end
    tick();
    clr_inputs();
    // A stray write-back after reset must not wrap the in-flight count.
    for (int k = 1; k <= 5; k++) begin
      set_id(1, 5'd0, 0, 5'd0, 0, 5'(k), 1, 1);
      exp_q.push_back((k == 5) ? 5'b11001 : 5'b00000);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (ctrl !== e) begin errors++; $display("FAIL no_underflow[%0d] got=%b exp=%b", k, ctrl, e); end
      if (e[3]) bump_stalls();
      tick();
    end
    clr_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles_o !== exp_stalls) begin errors++; $display("FAIL final_cnt got=%0d exp=%0d", stall_cycles_o, exp_stalls); end
    tick();
  endtask

  initial begin
    exp_stalls = 0;
    test_reset();
    test_raw_load();
    test_full();
    test_redirect();
    test_mem_busy();
    test_x0();
    test_saturate_and_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
